// File: rtl/riscv_l0_multiline_buffer_if.sv
// Core-fetch and instruction-memory signals of the L0 multi-line buffer.
// The buffer uses the slave view; the surrounding core/memory side uses the master view.
interface riscv_l0_multiline_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  fetch_req_i;
  logic [ADDR_WIDTH-1:0] fetch_addr_i;
  logic                  branch_i;
  logic                  flush_i;
  logic                  fetch_gnt_o;
  logic                  fetch_valid_o;
  logic [31:0]           fetch_rdata_o;
  logic [ADDR_WIDTH-1:0] fetch_addr_o;
  logic                  instr_req_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;
  logic                  instr_gnt_i;
  logic                  instr_rvalid_i;
  logic [LINE_WIDTH-1:0] instr_rdata_i;
  logic                  busy_o;

  modport slave (
    input  fetch_req_i, fetch_addr_i, branch_i, flush_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fetch_gnt_o, fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    output instr_req_o, instr_addr_o, busy_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i, branch_i, flush_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fetch_gnt_o, fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    input  instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/riscv_l0_multiline_buffer.sv
// Fully-associative L0 instruction buffer: NUM_LINES tagged lines, invalid-first/round-robin refill,
// flush and branch kill. Next-line prefetch is built in when RISCV_L0_NEXTLINE_PREFETCH_EN is defined.
module riscv_l0_multiline_buffer #(
  parameter int LINE_WIDTH = 128,
  parameter int NUM_LINES  = 2,
  parameter int ADDR_WIDTH = 32
) (
  input logic                        clk,
  input logic                        rst_n,
  riscv_l0_multiline_buffer_if.slave bus
);
  localparam int OFFS_W = $clog2(LINE_WIDTH / 8);
  localparam int TAG_W  = ADDR_WIDTH - OFFS_W;
  localparam int WORD_W = OFFS_W - 2;
  localparam int PTR_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

`ifdef RISCV_L0_NEXTLINE_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, WAIT_GNT, WAIT_RVALID, PF_GNT, PF_RVALID} state_e;
`else
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;
`endif

  state_e                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [TAG_W-1:0]      addr_q, addr_d;
  logic                  discard_q, discard_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;

  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [LINE_WIDTH-1:0] data_q [NUM_LINES];

  logic [TAG_W-1:0]  req_tag, mem_tag;
  logic [WORD_W-1:0] word_idx;
  logic              hit_any, serve_ok, hit_gnt, miss, kill, fill_we, victim_free, mem_req;
  logic [PTR_W-1:0]  hit_idx, victim_idx, ptr_inc;

  assign req_tag  = bus.fetch_addr_i[ADDR_WIDTH-1:OFFS_W];
  assign word_idx = bus.fetch_addr_i[OFFS_W-1:2];
  assign kill     = bus.branch_i | bus.flush_i;
  assign ptr_inc  = (ptr_q == PTR_W'(NUM_LINES - 1)) ? '0 : ptr_q + 1'b1;

  // Descending scan so the lowest-index invalid entry wins the victim choice.
  always_comb begin
    hit_any     = 1'b0;
    hit_idx     = '0;
    victim_free = 1'b0;
    victim_idx  = ptr_q;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        hit_any = 1'b1;
        hit_idx = PTR_W'(i);
      end
      if (!valid_q[i]) begin
        victim_free = 1'b1;
        victim_idx  = PTR_W'(i);
      end
    end
  end

`ifdef RISCV_L0_NEXTLINE_PREFETCH_EN
  logic [TAG_W-1:0] pf_tag;
  logic             pf_resident;

  // The entry about to be overwritten no longer counts as holding line+1.
  always_comb begin
    pf_tag      = addr_q + 1'b1;
    pf_resident = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && tag_q[i] == pf_tag && PTR_W'(i) != victim_idx) pf_resident = 1'b1;
    end
  end

  assign serve_ok = (state_q == IDLE) || (state_q == PF_GNT) || (state_q == PF_RVALID);
`else
  assign serve_ok = (state_q == IDLE);
`endif

  assign hit_gnt = bus.fetch_req_i & hit_any & serve_ok & ~bus.flush_i;
  assign miss    = bus.fetch_req_i & ~hit_any & ~bus.flush_i;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    ptr_d     = ptr_q;
    valid_d   = bus.flush_i ? '0 : valid_q;
    mem_req   = 1'b0;
    mem_tag   = addr_q;
    fill_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          mem_req = 1'b1;
          mem_tag = req_tag;
          addr_d  = req_tag;
          state_d = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        mem_req = 1'b1;
        if (bus.branch_i) begin
          mem_tag = req_tag;
          addr_d  = req_tag;
        end
        if (bus.instr_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (bus.instr_rvalid_i) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          fill_we   = ~(discard_q | kill);
`ifdef RISCV_L0_NEXTLINE_PREFETCH_EN
          if (fill_we && !pf_resident) begin
            state_d = PF_GNT;
            addr_d  = pf_tag;
          end
`endif
        end else if (kill) begin
          discard_d = 1'b1;
        end
      end
`ifdef RISCV_L0_NEXTLINE_PREFETCH_EN
      PF_GNT: begin
        if (kill) begin
          state_d = IDLE;
        end else if (miss) begin
          mem_req = 1'b1;
          mem_tag = req_tag;
          addr_d  = req_tag;
          state_d = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else begin
          mem_req = 1'b1;
          if (bus.instr_gnt_i) state_d = PF_RVALID;
        end
      end
      PF_RVALID: begin
        if (bus.instr_rvalid_i) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          fill_we   = ~(discard_q | kill);
        end else if (kill) begin
          discard_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (fill_we) begin
      valid_d[victim_idx] = 1'b1;
      if (!victim_free) ptr_d = ptr_inc;
    end
  end

  always_comb begin
    rsp_valid_d = hit_gnt;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    if (hit_gnt) begin
      rsp_rdata_d = data_q[hit_idx][{word_idx, 5'd0} +: 32];
      rsp_addr_d  = bus.fetch_addr_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      discard_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      discard_q   <= discard_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  // NOTE: line storage is not reset; valid_q alone decides whether an entry's contents mean anything.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[victim_idx] <= bus.instr_rdata_i;
      tag_q[victim_idx]  <= addr_q;
    end
  end

  assign bus.fetch_gnt_o   = hit_gnt;
  assign bus.fetch_valid_o = rsp_valid_q & ~bus.branch_i;
  assign bus.fetch_rdata_o = rsp_rdata_q;
  assign bus.fetch_addr_o  = rsp_addr_q;
  assign bus.instr_req_o   = mem_req;
  assign bus.instr_addr_o  = {mem_tag, {OFFS_W{1'b0}}};
  assign bus.busy_o        = (state_q != IDLE) | mem_req;
endmodule

// File: doc/riscv_l0_multiline_buffer.md
Name: riscv_L0_multiline_buffer

Overview:
- Parametrised successor to the single-line L0 instruction buffer. It sits between the prefetcher and the instruction memory port.
- Holds NUM_LINES fully-associative, line-aligned instruction lines, each tagged by line address.
- Serves 32-bit words to the core on a hit and fetches missing lines with a req/gnt/rvalid handshake.
- Adds round-robin replacement, flush (fence.i) and optional next-line prefetch.

Parameters:
- LINE_WIDTH, 128, bits per line; power of two, 64..512.
- NUM_LINES, 2, number of line entries; power of two, 1..8.
- ADDR_WIDTH, 32, address width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_req_i  in  1  core word request; held until fetch_gnt_o
- fetch_addr_i  in  ADDR_WIDTH  word address; bits [1:0] ignored
- branch_i  in  1  redirect; kills in-flight fill and pending response
- flush_i  in  1  invalidate all lines
- fetch_gnt_o  out  1  request accepted (combinational)
- fetch_valid_o  out  1  response valid
- fetch_rdata_o  out  32  response word
- fetch_addr_o  out  ADDR_WIDTH  word address of response
- instr_req_o  out  1  memory request
- instr_addr_o  out  ADDR_WIDTH  line-aligned memory address (low log2(LINE_WIDTH/8) bits zero)
- instr_gnt_i  in  1  memory grant
- instr_rvalid_i  in  1  memory response valid
- instr_rdata_i  in  LINE_WIDTH  memory line data
- busy_o  out  1  state != IDLE or instr_req_o

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; all valid bits 0; replacement pointer 0; discard flag 0.
  - All outputs 0.
- Hit rule: fetch_req_i, and some valid entry's tag equals fetch_addr_i line address.
  - Hits are served only in IDLE, and in PF_GNT/PF_RVALID when prefetch is enabled.
  - On a hit, fetch_gnt_o=1 in the same cycle.
  - Next cycle: fetch_valid_o=1, fetch_rdata_o = selected word (index = addr[log2(LINE_WIDTH/8)-1:2]), fetch_addr_o = the request address.
  - fetch_valid_o is gated with ~branch_i.
- Miss flow:
  - IDLE, fetch_req_i, no hit: instr_req_o=1 with the line address; go to WAIT_RVALID if instr_gnt_i, else WAIT_GNT.
  - No fetch_gnt_o is given on a miss.
- WAIT_GNT:
  - instr_req_o=1, holding the latched address.
  - branch_i replaces the address with the new target's line address.
  - instr_gnt_i moves to WAIT_RVALID.
- WAIT_RVALID:
  - On instr_rvalid_i, write the line into the entry at the replacement pointer and set its tag and valid bit. Pointer increments mod NUM_LINES.
  - Return to IDLE.
  - The held core request hits the next cycle: gnt at rvalid+1, valid at rvalid+2. No forwarding.
- Victim choice: an invalid entry is chosen before the pointer (lowest index first). The pointer advances only when a valid entry is overwritten.
- branch_i in WAIT_RVALID sets the discard flag. The arriving line is dropped (not written) and the FSM returns to IDLE. The flag clears on that rvalid.
- flush_i:
  - All valid bits clear next cycle.
  - A fill in flight is discarded as if branch_i.
  - flush_i has priority over a same-cycle hit: no gnt.
- Memory port: at most one outstanding memory transaction. instr_req_o is never asserted in WAIT_RVALID.
- NUM_LINES=1 degenerates to single-line behaviour; the pointer stays 0.

Optional Feature:
- Macro: RISCV_L0_NEXTLINE_PREFETCH_EN.
- Defined:
  - After a demand fill completes, if line+1 is not resident, the FSM enters PF_GNT, issuing a request for line address + LINE_WIDTH/8, then PF_RVALID.
  - Hits continue to be served in PF_GNT and PF_RVALID.
  - A demand miss in PF_GNT aborts the prefetch and issues the demand address instead.
  - A demand miss in PF_RVALID waits for the prefetch rvalid, then proceeds.
  - branch_i or flush_i discards the prefetch.
  - Address wraps modulo 2^ADDR_WIDTH.
- Undefined: PF states are absent; the FSM returns to IDLE after every fill.

Test Plan:
- Cold miss: reset; fetch_req_i, addr 0x100; gnt same cycle; rvalid 2 cycles later with data word2=0xDEADBEEF. Required: instr_addr_o=0x100; fetch_gnt_o at rvalid+1; fetch_valid_o with rdata 0x00000000 (word0) at rvalid+2.
- Hit: after the fill, request 0x108. Required: gnt same cycle; next cycle rdata=0xDEADBEEF, fetch_addr_o=0x108; instr_req_o stays 0.
- Replacement (NUM_LINES=2): fill lines 0x100, 0x200, 0x300. Required: 0x300 overwrites 0x100. A request to 0x100 then misses; a request to 0x200 hits.
- Branch kill: miss on 0x400, branch_i to 0x500 while in WAIT_RVALID. Required: rvalid data not stored; 0x400 later misses; next instr_addr_o=0x500.
- Flush: two lines resident; pulse flush_i. Required: next request to either line misses; busy_o=1 until the refill completes.
- With RISCV_L0_NEXTLINE_PREFETCH_EN: miss on 0x100 completes. Required: instr_req_o to 0x110 follows without a core request; a later request to 0x110 hits.
